// File: rtl/noise_run_sequencer_if.sv
// Bundle between the run sequencer and its host/noise-generator side.
// master = host + generator model, slave = noise_run_sequencer.
interface noise_run_sequencer_if #(
    parameter int CNT_W = 48
);
    // start and abort are sampled on every rising edge with no ready return:
    // start only counts in IDLE, abort only outside IDLE, and gen_valid is a
    // per-cycle qualifier that the sequencer never back-pressures.
    logic             cfg_wr_en;
    logic [5:0]       cfg_wr_addr;
    logic [63:0]      cfg_wr_data;
    logic [CNT_W-1:0] sample_count;
    logic             start;
    logic             abort;
    logic             gen_rstn;
    logic [31:0]      gen_prob_idx;
    logic [63:0]      gen_prob_in;
    logic             gen_en;
    logic             gen_valid;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err_nonmono;
    logic [5:0]       err_idx;
    logic [CNT_W-1:0] samples_done;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, sample_count, start, abort, gen_valid,
        input  gen_rstn, gen_prob_idx, gen_prob_in, gen_en, busy, done, aborted,
               err_nonmono, err_idx, samples_done
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, sample_count, start, abort, gen_valid,
        output gen_rstn, gen_prob_idx, gen_prob_in, gen_en, busy, done, aborted,
               err_nonmono, err_idx, samples_done
    );
endinterface

// File: rtl/noise_run_sequencer.sv
// Sequences one noise-generator run: table load with monotonic check, settle,
// counted enable window, drain, completion pulse; abort and rst at any point.
module noise_run_sequencer #(
    parameter int TABLE_DEPTH = 64,
    parameter int CNT_W       = 48
) (
    input  logic                clk,
    input  logic                rst,
    noise_run_sequencer_if.slave bus,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [5:0]  LAST_IDX = 6'(TABLE_DEPTH - 1);
    localparam logic [31:0] IDX_IDLE = 32'hFFFF_FFFF;

    state_t           state;
    logic [63:0]      tbl [TABLE_DEPTH];
    logic [5:0]       load_idx;
    logic [CNT_W-1:0] count_lat;
    logic [CNT_W-1:0] run_left;
    logic             phase;
    logic             nonmono;

    assign dbg_state = state;

    // Shadow table has no reset so a host-loaded table survives rst.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en && state == S_IDLE) begin
            tbl[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    // Compares the entry being presented this cycle against its predecessor.
    assign nonmono = (state == S_LOAD) && (load_idx != 6'd0) &&
                     (tbl[load_idx] < tbl[load_idx - 6'd1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            bus.gen_rstn     <= 1'b0;
            bus.gen_en       <= 1'b0;
            bus.gen_prob_idx <= IDX_IDLE;
            bus.gen_prob_in  <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.aborted      <= 1'b0;
            bus.err_nonmono  <= 1'b0;
            bus.err_idx      <= '0;
            bus.samples_done <= '0;
            load_idx         <= '0;
            count_lat        <= '0;
            run_left         <= '0;
            phase            <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
            if ((state == S_RUN || state == S_DRAIN) && bus.gen_valid && !bus.abort &&
                bus.samples_done != '1) begin
                bus.samples_done <= bus.samples_done + CNT_W'(1);
            end
            if (state != S_IDLE && bus.abort) begin
                state            <= S_IDLE;
                bus.gen_rstn     <= 1'b1;
                bus.gen_en       <= 1'b0;
                bus.gen_prob_idx <= IDX_IDLE;
                bus.busy         <= 1'b0;
                bus.aborted      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        bus.gen_rstn     <= 1'b1;
                        bus.gen_en       <= 1'b0;
                        bus.gen_prob_idx <= IDX_IDLE;
                        bus.busy         <= 1'b0;
                        if (bus.start) begin
                            state            <= S_LOAD;
                            bus.gen_rstn     <= 1'b0;
                            bus.gen_prob_idx <= 32'd0;
                            bus.gen_prob_in  <= tbl[0];
                            bus.busy         <= 1'b1;
                            bus.samples_done <= '0;
                            bus.err_nonmono  <= 1'b0;
                            load_idx         <= '0;
                            count_lat        <= bus.sample_count;
                        end
                    end
                    S_LOAD: begin
                        if (nonmono) begin
                            state            <= S_IDLE;
                            bus.err_nonmono  <= 1'b1;
                            bus.err_idx      <= load_idx;
                            bus.aborted      <= 1'b1;
                            bus.busy         <= 1'b0;
                            bus.gen_rstn     <= 1'b1;
                            bus.gen_prob_idx <= IDX_IDLE;
                        end else if (load_idx == LAST_IDX) begin
                            state            <= S_SETTLE;
                            phase            <= 1'b0;
                            bus.gen_prob_idx <= IDX_IDLE;
                        end else begin
                            load_idx         <= load_idx + 6'd1;
                            bus.gen_prob_idx <= {26'd0, load_idx + 6'd1};
                            bus.gen_prob_in  <= tbl[load_idx + 6'd1];
                        end
                    end
                    S_SETTLE: begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else if (count_lat == '0) begin
                            state        <= S_DONE;
                            bus.done     <= 1'b1;
                            bus.gen_rstn <= 1'b1;
                        end else begin
                            state        <= S_RUN;
                            bus.gen_rstn <= 1'b1;
                            bus.gen_en   <= 1'b1;
                            run_left     <= count_lat - CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (run_left == '0) begin
                            state      <= S_DRAIN;
                            bus.gen_en <= 1'b0;
                            phase      <= 1'b0;
                        end else begin
                            run_left <= run_left - CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_noise_run_sequencer.sv
// Bench for noise_run_sequencer: a per-cycle trace model built from the run
// rules, checked every cycle, plus hand-computed literal expectations.
module tb_noise_run_sequencer;
    localparam int CNT_W = 8;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic             rstn;
        logic             en;
        logic [31:0]      idx;
        logic [63:0]      data;
        logic             busy;
        logic             done;
        logic             aborted;
        logic             err;
        logic [5:0]       err_idx;
        logic [CNT_W-1:0] sd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  dbg_state;
    logic        gv_d = 1'b0;
    logic        valid_all = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    bit chk_on = 1'b0;
    int en_cnt, load_cnt, settle_cnt, done_cnt, abort_cnt;

    exp_t             exp_q[$];
    logic [63:0]      m_tbl [DEPTH];
    logic [CNT_W-1:0] h_sd = '0;
    logic             h_err = 1'b0;
    logic [5:0]       h_err_idx = '0;

    noise_run_sequencer_if #(.CNT_W(CNT_W)) bus ();

    noise_run_sequencer #(.TABLE_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / generator model: gen_valid follows gen_en by one cycle
    always #5 clk = ~clk;
    always @(posedge clk) gv_d <= bus.gen_en;
    assign bus.gen_valid = valid_all | gv_d;

    // scoreboard: one expected entry per cycle, idle expectation when empty
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (chk_on) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '0;
                e.rstn = 1'b1;
                e.idx = 32'hFFFF_FFFF;
                e.err = h_err;
                e.err_idx = h_err_idx;
                e.sd = h_sd;
            end
            h_sd = e.sd;
            h_err = e.err;
            h_err_idx = e.err_idx;
            tests++;
            if (bus.gen_rstn !== e.rstn || bus.gen_en !== e.en || bus.gen_prob_idx !== e.idx ||
                (e.idx != 32'hFFFF_FFFF && bus.gen_prob_in !== e.data) || bus.busy !== e.busy ||
                bus.done !== e.done || bus.aborted !== e.aborted || bus.err_nonmono !== e.err ||
                bus.err_idx !== e.err_idx || bus.samples_done !== e.sd) begin
                fails++;
                $display("FAIL cycle_check cyc=%0d got rstn=%b en=%b idx=%h in=%h busy=%b done=%b abt=%b err=%b eidx=%0d sd=%0d exp rstn=%b en=%b idx=%h in=%h busy=%b done=%b abt=%b err=%b eidx=%0d sd=%0d",
                         cyc, bus.gen_rstn, bus.gen_en, bus.gen_prob_idx, bus.gen_prob_in, bus.busy,
                         bus.done, bus.aborted, bus.err_nonmono, bus.err_idx, bus.samples_done,
                         e.rstn, e.en, e.idx, e.data, e.busy, e.done, e.aborted, e.err, e.err_idx, e.sd);
            end
            if (bus.gen_en) en_cnt++;
            if (!bus.gen_rstn && bus.gen_prob_idx != 32'hFFFF_FFFF) load_cnt++;
            if (!bus.gen_rstn && bus.gen_prob_idx == 32'hFFFF_FFFF) settle_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.aborted) abort_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0; load_cnt = 0; settle_cnt = 0; done_cnt = 0; abort_cnt = 0;
    endtask

    // Expected per-cycle outputs of one run, starting with the first LOAD cycle.
    task automatic build_trace(input int cnt, input int abort_at, input bit all_valid);
        exp_t tr[$];
        bit   cntf[$];
        exp_t e;
        int   bad = -1;
        int   sd = 0;
        int   smax = (1 << CNT_W) - 1;
        e = '0;
        e.busy = 1'b1;
        e.err_idx = h_err_idx;
        for (int k = 0; k < DEPTH; k++) begin
            e.idx = 32'(k);
            e.data = m_tbl[k];
            tr.push_back(e); cntf.push_back(1'b0);
            if (k > 0 && m_tbl[k] < m_tbl[k-1]) begin
                bad = k;
                break;
            end
        end
        if (bad < 0) begin
            e.idx = 32'hFFFF_FFFF;
            e.data = '0;
            repeat (2) begin tr.push_back(e); cntf.push_back(1'b0); end
            e.rstn = 1'b1;
            e.en = 1'b1;
            repeat (cnt) begin tr.push_back(e); cntf.push_back(1'b1); end
            e.en = 1'b0;
            if (cnt > 0) repeat (2) begin tr.push_back(e); cntf.push_back(1'b1); end
            e.done = 1'b1;
            tr.push_back(e); cntf.push_back(1'b0);
        end
        // value seen in cycle j reflects valid cycles strictly before j
        for (int j = 0; j < tr.size(); j++) begin
            tr[j].sd = CNT_W'(sd);
            if (cntf[j] && (all_valid || (j > 0 && tr[j-1].en))) sd = (sd < smax) ? sd + 1 : smax;
        end
        if (bad >= 0) begin
            e = tr[tr.size()-1];
            e.err = 1'b1;
            e.err_idx = 6'(bad);
        end else if (abort_at >= 0 && abort_at < tr.size()) begin
            while (tr.size() > abort_at + 1) void'(tr.pop_back());
            e = tr[abort_at];
        end
        if (bad >= 0 || (abort_at >= 0 && abort_at < tr.size())) begin
            e.rstn = 1'b1; e.en = 1'b0; e.idx = 32'hFFFF_FFFF; e.busy = 1'b0;
            e.done = 1'b0; e.aborted = 1'b1;
            tr.push_back(e);
        end
        foreach (tr[i]) exp_q.push_back(tr[i]);
    endtask

    // driver tasks: called and returning at posedge+1
    task automatic start_run(input int cnt, input int abort_at, input bit all_valid, input bit with_abort);
        bus.sample_count = CNT_W'(cnt);
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        start_cyc = cyc;
        build_trace(cnt, abort_at, all_valid);
        if (abort_at >= 0) begin
            repeat (abort_at) begin @(posedge clk); #1; end
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
        end
    endtask

    task automatic cfg_write(input int addr, input logic [63:0] data, input bit taken);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_wr_addr = 6'(addr);
        bus.cfg_wr_data = data;
        if (taken) m_tbl[addr] = data;
        @(posedge clk); #1;
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s_timeout waited=%0d cycles limit=%0d", name, n, budget);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL global_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.sample_count = '0; bus.start = 1'b0; bus.abort = 1'b0;
        clear_mon();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_gen_rstn", 64'(bus.gen_rstn), 64'd0);
        check("rst_gen_en", 64'(bus.gen_en), 64'd0);
        check("rst_prob_idx", 64'(bus.gen_prob_idx), 64'hFFFF_FFFF);
        check("rst_prob_in", bus.gen_prob_in, 64'd0);
        check("rst_busy_done_abt", {61'd0, bus.busy, bus.done, bus.aborted}, 64'd0);
        check("rst_err", {57'd0, bus.err_nonmono, bus.err_idx}, 64'd0);
        check("rst_samples", 64'(bus.samples_done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_gen_rstn", 64'(bus.gen_rstn), 64'd1);
        chk_on = 1'b1;

        for (int k = 0; k < DEPTH; k++) cfg_write(k, 64'(k) << 57, 1'b1);

        // normal run, count 10
        clear_mon();
        start_run(10, -1, 1'b0, 1'b0);
        wait_idle("normal", 300);
        check("normal_load_cycles", 64'(load_cnt), 64'd64);
        check("normal_settle_cycles", 64'(settle_cnt), 64'd2);
        check("normal_en_cycles", 64'(en_cnt), 64'd10);
        check("normal_done_pulses", 64'(done_cnt), 64'd1);
        check("normal_done_latency", 64'(done_cyc - start_cyc), 64'd79);
        check("normal_samples", 64'(bus.samples_done), 64'd10);

        // zero count
        clear_mon();
        start_run(0, -1, 1'b0, 1'b0);
        wait_idle("zero", 300);
        check("zero_done_latency", 64'(done_cyc - start_cyc), 64'd67);
        check("zero_en_cycles", 64'(en_cnt), 64'd0);
        check("zero_samples", 64'(bus.samples_done), 64'd0);

        // non-monotonic entry 20
        cfg_write(20, (64'd19 << 57) - 64'd1, 1'b1);
        clear_mon();
        start_run(10, -1, 1'b0, 1'b0);
        wait_idle("nonmono", 300);
        check("nonmono_flag", 64'(bus.err_nonmono), 64'd1);
        check("nonmono_idx", 64'(bus.err_idx), 64'd20);
        check("nonmono_en_cycles", 64'(en_cnt), 64'd0);
        check("nonmono_aborted", 64'(abort_cnt), 64'd1);
        check("nonmono_load_cycles", 64'(load_cnt), 64'd21);
        cfg_write(20, 64'd20 << 57, 1'b1);

        // abort during the 5th RUN cycle of 100
        clear_mon();
        start_run(100, 70, 1'b0, 1'b0);
        wait_idle("abort", 400);
        check("abort_en_cycles", 64'(en_cnt), 64'd5);
        check("abort_pulses", 64'(abort_cnt), 64'd1);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_samples", 64'(bus.samples_done), 64'd3);
        check("abort_err_cleared", 64'(bus.err_nonmono), 64'd0);

        // start and cfg write while busy are ignored
        clear_mon();
        start_run(30, -1, 1'b0, 1'b0);
        repeat (70) begin @(posedge clk); #1; end
        bus.start = 1'b1;
        cfg_write(5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        bus.start = 1'b0;
        wait_idle("busy_ignore", 400);
        check("busy_ignore_done_pulses", 64'(done_cnt), 64'd1);
        start_run(3, -1, 1'b0, 1'b0);
        wait_idle("table_unchanged", 300);

        // start with abort in IDLE starts; abort alone in IDLE does nothing
        clear_mon();
        start_run(2, -1, 1'b0, 1'b1);
        wait_idle("start_abort", 300);
        check("start_abort_done", 64'(done_cnt), 64'd1);
        check("start_abort_no_abt", 64'(abort_cnt), 64'd0);
        bus.abort = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.abort = 1'b0;
        @(posedge clk); #1;
        check("idle_abort_ignored", 64'(abort_cnt), 64'd0);

        // saturation: 256 valid cycles into an 8-bit counter
        valid_all = 1'b1;
        start_run(254, -1, 1'b1, 1'b0);
        wait_idle("saturate", 600);
        check("saturate_samples", 64'(bus.samples_done), 64'hFF);
        valid_all = 1'b0;

        // rst mid-run, then the table must still be intact
        clear_mon();
        start_run(50, -1, 1'b0, 1'b0);
        repeat (80) begin @(posedge clk); #1; end
        rst = 1'b1;
        chk_on = 1'b0;
        exp_q.delete();
        h_sd = '0; h_err = 1'b0; h_err_idx = '0;
        repeat (2) begin @(posedge clk); #1; end
        check("midrst_flags", {60'd0, bus.busy, bus.done, bus.aborted, bus.gen_en}, 64'd0);
        check("midrst_samples", 64'(bus.samples_done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        start_run(1, -1, 1'b0, 1'b0);
        wait_idle("post_rst_run", 300);
        check("midrst_no_pulses", 64'(abort_cnt), 64'd0);
        check("post_rst_done", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
